// File: rtl/stream_arbiter.sv
// stream_arbiter: round-robin, packet-locked arbiter sharing one valid/ready stream between PORTS requesters
module stream_arbiter #(
  parameter int WIDTH = 32,
  parameter int PORTS = 4,
  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [PORTS-1:0]       in_valid,
  output logic [PORTS-1:0]       in_ready,
  input  logic [PORTS*WIDTH-1:0] in_data,
  input  logic [PORTS-1:0]       in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_last,
  output logic [PW-1:0]          out_port
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_nx;
  logic [PW-1:0] grant, grant_nx, rr_ptr, rr_nx, pick, sec_port;
  logic [WIDTH-1:0] sec_data, acc_data;
  logic sec_last, acc_last, buf_ready, push, pop;
  logic [1:0] count, count_nx;

  // first requesting port at or after rr_ptr, wrapping at PORTS-1; lowest offset wins
  always_comb begin
    pick = rr_ptr;
    for (int i = PORTS - 1; i >= 0; i--)
      if (in_valid[PW'((int'(rr_ptr) + i) % PORTS)]) pick = PW'((int'(rr_ptr) + i) % PORTS);
  end

  // lock onto a requester in IDLE, release after its last beat is accepted
  always_comb begin
    state_nx = state;
    grant_nx = grant;
    rr_nx = rr_ptr;
    in_ready = '0;
    if (state == LOCKED) in_ready[grant] = buf_ready;
    push = (state == LOCKED) && in_valid[grant] && buf_ready;
    acc_data = in_data[int'(grant)*WIDTH +: WIDTH];
    acc_last = in_last[grant];
    if (state == IDLE && |in_valid) begin
      state_nx = LOCKED;
      grant_nx = pick;
    end
    if (push && acc_last) begin
      state_nx = IDLE;
      rr_nx = PW'((int'(grant) + 1) % PORTS);
    end
  end

  assign pop = out_valid && out_ready;
  assign count_nx = count + {1'b0, push} - {1'b0, pop};

  // arbitration state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      grant <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      rr_ptr <= rr_nx;
    end
  end

  // two-entry buffer: head drives the outputs, second entry absorbs the beat accepted while the head stalls
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      out_valid <= 1'b0;
      buf_ready <= 1'b1;
      out_data <= '0;
      out_last <= 1'b0;
      out_port <= '0;
      sec_data <= '0;
      sec_last <= 1'b0;
      sec_port <= '0;
    end else begin
      count <= count_nx;
      out_valid <= count_nx != 2'd0;
      buf_ready <= count_nx != 2'd2;
      if (count == 2'd2 && pop) begin
        out_data <= sec_data;
        out_last <= sec_last;
        out_port <= sec_port;
      end else if (push && (count == 2'd0 || pop)) begin
        out_data <= acc_data;
        out_last <= acc_last;
        out_port <= grant;
      end else if (push) begin
        sec_data <= acc_data;
        sec_last <= acc_last;
        sec_port <= grant;
      end
    end
  end
endmodule
